// File: rtl/tdm_audio_port.sv
// Master-mode 8-slot TDM port: bclk/fs generation, DAC serializer, ADC deserializer.
// Latency: outputs captured at frame start; inputs presented one clk after last rising bclk.
// Backpressure: none, free-running; DSP must consume audio_inputs within one frame.
module tdm_audio_port #(
  parameter int IO_WIDTH   = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IO_WIDTH-1:0] audio_outputs [0:7],
  output logic [IO_WIDTH-1:0] audio_inputs  [0:7],
  output logic                frame_strobe,
  output logic                tdm_bclk,
  output logic                tdm_fs,
  output logic                tdm_sdout,
  input  logic                tdm_sdin
);

  localparam int DW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW  = $clog2(SLOT_WIDTH);
  localparam int BW1 = BW + 1;
  localparam int CW  = BW + 3;

  localparam logic [DW-1:0]  DIV_RISE = DW'(BCLK_DIV / 2 - 1);
  localparam logic [DW-1:0]  DIV_FALL = DW'(BCLK_DIV - 1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(8 * SLOT_WIDTH - 1);
  localparam logic [BW1-1:0] IO_W     = BW1'(IO_WIDTH);
  localparam logic [BW-1:0]  IO_LAST  = BW'(IO_WIDTH - 1);

  logic [DW-1:0]       div;
  logic                rise_evt;
  logic                fall_evt;
  logic [CW-1:0]       bitcnt;
  logic [CW-1:0]       bitcnt_nxt;
  logic                frame_last;
  logic [2:0]          slot;
  logic [2:0]          slot_nxt;
  logic [BW-1:0]       bitpos;
  logic [BW-1:0]       bitpos_nxt;
  logic [IO_WIDTH-1:0] shadow      [0:7];
  logic [IO_WIDTH-1:0] shadow_nxt  [0:7];
  logic [IO_WIDTH-1:0] out_word;
  logic                sdout_nxt;
  logic [IO_WIDTH-1:0] in_shift;
  logic [IO_WIDTH-1:0] shift_nxt;
  logic                sample_en;
  logic [IO_WIDTH-1:0] in_buf      [0:7];
  logic [IO_WIDTH-1:0] in_buf_nxt  [0:7];

  assign rise_evt   = (div == DIV_RISE);
  assign fall_evt   = (div == DIV_FALL);
  assign frame_last = (bitcnt == BIT_LAST);
  assign slot       = bitcnt[CW-1 -: 3];
  assign bitpos     = bitcnt[BW-1:0];
  // Bit counter is a power of two wide, so the last bit wraps to 0 naturally.
  assign bitcnt_nxt = bitcnt + 1'b1;
  assign slot_nxt   = bitcnt_nxt[CW-1 -: 3];
  assign bitpos_nxt = bitcnt_nxt[BW-1:0];

  // Free-running bclk divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (fall_evt) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Registered bit clock: rises on rise_evt, falls on fall_evt (50% duty).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdm_bclk <= 1'b0;
    end else if (rise_evt) begin
      tdm_bclk <= 1'b1;
    end else if (fall_evt) begin
      tdm_bclk <= 1'b0;
    end
  end

  // Next shadow and serial bit; the frame-start word comes straight from the
  // DSP array so slot 0 bit 0 is not a frame late.
  always_comb begin
    shadow_nxt = shadow;
    if (frame_last) begin
      shadow_nxt = audio_outputs;
    end
    out_word  = shadow_nxt[slot_nxt] << bitpos_nxt;
    sdout_nxt = ({1'b0, bitpos_nxt} < IO_W) && out_word[IO_WIDTH-1];
  end

  // Transmit side: advance bit position and launch fs/sdout on falling bclk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt    <= BIT_LAST;
      tdm_fs    <= 1'b0;
      tdm_sdout <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        shadow[k] <= '0;
      end
    end else if (fall_evt) begin
      bitcnt    <= bitcnt_nxt;
      shadow    <= shadow_nxt;
      tdm_fs    <= (bitcnt_nxt == '0);
      tdm_sdout <= sdout_nxt;
    end
  end

  // Receive datapath: shift MSB-first, complete word lands in its slot buffer.
  always_comb begin
    shift_nxt  = (in_shift << 1) | IO_WIDTH'(tdm_sdin);
    sample_en  = rise_evt && ({1'b0, bitpos} < IO_W);
    in_buf_nxt = in_buf;
    if (rise_evt && (bitpos == IO_LAST)) begin
      in_buf_nxt[slot] = shift_nxt;
    end
  end

  // Receive side: sample sdin on rising bclk, publish the buffer at frame end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_shift     <= '0;
      frame_strobe <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        in_buf[k]       <= '0;
        audio_inputs[k] <= '0;
      end
    end else begin
      frame_strobe <= rise_evt && frame_last;
      in_buf       <= in_buf_nxt;
      if (sample_en) begin
        in_shift <= shift_nxt;
      end
      // Uses in_buf_nxt so a full-width last slot is not lost.
      if (rise_evt && frame_last) begin
        audio_inputs <= in_buf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tdm_audio_port.sv
// Bench for tdm_audio_port: random/directed stimulus against a frame-level model.
// Model predicts each output from the elapsed clk count since reset release.
// Inputs are driven on the falling clk edge, outputs sampled there too.
module tb_tdm_audio_port;

  localparam int D  = 4;        // clk per bclk
  localparam int FB = 256;      // bits per frame
  localparam int FR = FB * D;   // clk per frame

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] audio_outputs [0:7];
  logic [23:0] audio_inputs  [0:7];
  logic        frame_strobe;
  logic        tdm_bclk;
  logic        tdm_fs;
  logic        tdm_sdout;
  logic        tdm_sdin;

  logic        loop_mode;
  logic        adc_bit;

  assign tdm_sdin = loop_mode ? tdm_sdout : adc_bit;

  tdm_audio_port #(.IO_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_outputs(audio_outputs),
    .audio_inputs (audio_inputs),
    .frame_strobe (frame_strobe),
    .tdm_bclk     (tdm_bclk),
    .tdm_fs       (tdm_fs),
    .tdm_sdout    (tdm_sdout),
    .tdm_sdin     (tdm_sdin)
  );

  always #5 clk = ~clk;

  // Rising clk edges since reset release.
  int n = 0;
  always @(posedge clk) begin
    if (!reset_n) n <= 0;
    else          n <= n + 1;
  end

  int total = 0;
  int bad   = 0;

  // Reference state: words on the wire this frame and expected DSP inputs.
  logic [23:0] frame_out [0:7];
  logic [23:0] frame_in  [0:7];
  logic [23:0] aud_exp   [0:7];
  logic [23:0] adc_next  [0:7];
  bit          rand_adc;
  bit          rand_outs;
  bit          pad_ones;
  int          change_at;
  logic [23:0] change_val;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_bclk"},   32'(tdm_bclk),     32'd0);
    check_val({tag, "_fs"},     32'(tdm_fs),       32'd0);
    check_val({tag, "_sdout"},  32'(tdm_sdout),    32'd0);
    check_val({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
    for (int s = 0; s < 8; s++) begin
      check_val($sformatf("%s_in%0d", tag, s), 32'(audio_inputs[s]), 32'd0);
    end
  endtask

  // Enter reset mid clk-low phase, check outputs clear at once, hold while toggling inputs.
  task automatic reset_hold(input int cyc);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_async");
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      check_all_zero("rst_hold");
      for (int s = 0; s < 8; s++) audio_outputs[s] = 24'($urandom);
      adc_bit = 1'($urandom);
    end
  endtask

  task automatic release_reset();
    for (int s = 0; s < 8; s++) begin
      frame_out[s] = '0;
      frame_in[s]  = '0;
      aud_exp[s]   = '0;
    end
    reset_n = 1'b1;
  endtask

  // One clk: update model for the edge just taken, compare, then drive inputs.
  task automatic step();
    int  k, p, sl, b;
    bit  strobe_exp, bclk_exp, fs_exp, sd_exp, pad;
    @(negedge clk);
    sl = 0;
    b  = 31;
    if (n >= D && (n - D) % FR == 0) begin
      frame_out = audio_outputs;
      for (int s = 0; s < 8; s++) begin
        if (loop_mode)     frame_in[s] = frame_out[s];
        else if (rand_adc) frame_in[s] = 24'($urandom);
        else               frame_in[s] = adc_next[s];
      end
    end
    strobe_exp = (n >= D / 2) && ((n - D / 2) % FR == 0);
    if (strobe_exp) aud_exp = frame_in;
    bclk_exp = (n % D) >= D / 2;
    fs_exp   = 1'b0;
    sd_exp   = 1'b0;
    if (n >= D) begin
      k  = n / D - 1;
      p  = k % FB;
      sl = p / 32;
      b  = p % 32;
      fs_exp = (p == 0);
      sd_exp = (b < 24) ? frame_out[sl][23 - b] : 1'b0;
    end
    check_val("bclk",   32'(tdm_bclk),     32'(bclk_exp));
    check_val("fs",     32'(tdm_fs),       32'(fs_exp));
    check_val("sdout",  32'(tdm_sdout),    32'(sd_exp));
    check_val("strobe", 32'(frame_strobe), 32'(strobe_exp));
    if (strobe_exp || (n % D == 0)) begin
      for (int s = 0; s < 8; s++) begin
        check_val($sformatf("ain%0d", s), 32'(audio_inputs[s]), 32'(aud_exp[s]));
      end
    end
    pad = pad_ones ? 1'b1 : 1'($urandom);
    adc_bit = (n >= D && b < 24) ? frame_in[sl][23 - b] : pad;
    if (rand_outs && $urandom_range(0, 15) == 0) begin
      audio_outputs[$urandom_range(0, 7)] = 24'($urandom);
    end
    if (n == change_at) audio_outputs[3] = change_val;
  endtask

  task automatic run_cycles(input int c);
    for (int i = 0; i < c; i++) step();
  endtask

  task automatic set_outputs_single(input logic [23:0] w0);
    for (int s = 0; s < 8; s++) audio_outputs[s] = '0;
    audio_outputs[0] = w0;
  endtask

  initial begin
    reset_n   = 1'b0;
    loop_mode = 1'b0;
    adc_bit   = 1'b0;
    rand_adc  = 1'b1;
    rand_outs = 1'b0;
    pad_ones  = 1'b0;
    change_at = -1;
    change_val = '0;
    for (int s = 0; s < 8; s++) begin
      audio_outputs[s] = '0;
      adc_next[s]      = '0;
    end
    @(negedge clk);

    // Reset state, then serialize a single word in slot 0.
    reset_hold(6);
    set_outputs_single(24'hA5A5A5);
    release_reset();
    run_cycles(2 * FR + 8);

    // Loopback of distinct words in every slot.
    reset_hold(3);
    loop_mode = 1'b1;
    for (int s = 0; s < 8; s++) audio_outputs[s] = 24'h100000 + 24'(s);
    release_reset();
    run_cycles(3 * FR);

    // Slot 3 word changes during slot 1: takes effect next frame only.
    reset_hold(3);
    for (int s = 0; s < 8; s++) audio_outputs[s] = 24'($urandom);
    audio_outputs[3] = 24'h000001;
    change_at  = D + 40 * D;
    change_val = 24'h7FFFFF;
    release_reset();
    run_cycles(3 * FR);
    change_at = -1;

    // ADC extreme values with all-ones padding.
    reset_hold(3);
    loop_mode = 1'b0;
    rand_adc  = 1'b0;
    pad_ones  = 1'b1;
    for (int s = 0; s < 8; s++) adc_next[s] = 24'($urandom);
    adc_next[0] = 24'h800000;
    adc_next[7] = 24'h7FFFFF;
    release_reset();
    run_cycles(2 * FR + D);

    // Fully random traffic with random padding and mid-frame output churn.
    reset_hold(3);
    rand_adc  = 1'b1;
    pad_ones  = 1'b0;
    rand_outs = 1'b1;
    for (int s = 0; s < 8; s++) audio_outputs[s] = 24'($urandom);
    release_reset();
    run_cycles(3 * FR);

    // Reset at bit 100, then restart as from power-up.
    reset_hold(3);
    rand_outs = 1'b0;
    set_outputs_single(24'hA5A5A5);
    release_reset();
    run_cycles(101 * D + 2);
    reset_hold(4);
    set_outputs_single(24'hA5A5A5);
    release_reset();
    run_cycles(2 * FR + 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
